seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller for the EGO1 stopwatch and later display designs. It runs in the single clk domain with an internal tick, so no derived clock is used. It drives N_DIGITS common-enable digits split across two segment buses, one per 4-digit group. Features beyond the first-generation scanner: per-digit decimal point and blank, leading-zero suppression, 8-level brightness PWM, frame-synchronous data latching, and selectable output polarity.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_tick_gen.sv | 60 ++++++
 rtl/seg7_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display family.
//   hex_to_seg : 4-bit nibble -> active-high {g,f,e,d,c,b,a} pattern
//   SEG_BLANK  : all segments off
//   SEG_DASH   : middle segment only
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Scan prescaler for seg7_scan_ctrl.
//   clk, rst    : clock, asynchronous active-low reset
//   sub_idx     : PWM sub-slot index 0..7 within the current digit slot
//   dig         : digit currently scanned, 0..N_DIGITS-1
//   frame_start : high while all counters are zero (first cycle of a frame)
// Internally sub_cnt divides clk by SUB to step sub_idx; sub_idx wrapping steps dig.
module seg7_tick_gen #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SUB      = 1,
  parameter int unsigned DIG_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [2:0]       sub_idx,
  output logic [DIG_W-1:0] dig,
  output logic             frame_start
);

  // Keep at least one bit so SUB == 1 still elaborates cleanly.
  localparam int unsigned CntW = (SUB > 1) ? $clog2(SUB) : 1;

  logic [CntW-1:0]  sub_cnt_q, sub_cnt_d;
  logic [2:0]       sub_idx_q, sub_idx_d;
  logic [DIG_W-1:0] dig_q, dig_d;

  logic sub_wrap, idx_wrap, dig_wrap;

  assign sub_wrap = (sub_cnt_q == CntW'(SUB - 1));
  assign idx_wrap = (sub_idx_q == 3'd7);
  assign dig_wrap = (dig_q == DIG_W'(N_DIGITS - 1));

  always_comb begin
    sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
    sub_idx_d = sub_idx_q;
    dig_d     = dig_q;
    if (sub_wrap) begin
      sub_idx_d = sub_idx_q + 3'd1;
      if (idx_wrap) begin
        dig_d = dig_wrap ? '0 : dig_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt_q <= '0;
      sub_idx_q <= '0;
      dig_q     <= '0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      sub_idx_q <= sub_idx_d;
      dig_q     <= dig_d;
    end
  end

  assign sub_idx     = sub_idx_q;
  assign dig         = dig_q;
  assign frame_start = (sub_cnt_q == '0) && (sub_idx_q == 3'd0) && (dig_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display controller with two 8-bit segment buses.
//   clk, rst   : clock, asynchronous active-low reset
//   data       : hex nibble per digit, digit i = data[4i+3:4i]
//   dp, blank  : per-digit decimal point / force-dark
//   lz_en      : leading-zero suppression enable
//   bright     : PWM level 0..7 (enable duty = (bright+1)/8)
//   an         : one-hot digit enable
//   seg0, seg1 : {dp,g,f,e,d,c,b,a} for digits 0..N/2-1 and N/2..N-1
//   frame_tick : one-cycle pulse when the shadow registers load
// All outputs are registered; ACTIVE_LOW inverts an/seg0/seg1 (not frame_tick).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 8,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 4000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lz_en,
  input  logic [2:0]            bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg0,
  output logic [7:0]            seg1,
  output logic                  frame_tick
);

  localparam int unsigned Slot = CLK_HZ / SCAN_HZ;
  localparam int unsigned Sub  = Slot / 8;
  localparam int unsigned DigW = $clog2(N_DIGITS);
  localparam int unsigned Half = N_DIGITS / 2;

  localparam logic [N_DIGITS-1:0] AnPol  = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]          SegPol = {8{ACTIVE_LOW}};

  logic [2:0]      sub_idx;
  logic [DigW-1:0] dig;
  logic            frame_start;

  seg7_tick_gen #(
    .N_DIGITS (N_DIGITS),
    .SUB      (Sub),
    .DIG_W    (DigW)
  ) u_tick_gen (
    .clk         (clk),
    .rst         (rst),
    .sub_idx     (sub_idx),
    .dig         (dig),
    .frame_start (frame_start)
  );

  // Shadow registers, loaded once per frame.
  logic [4*N_DIGITS-1:0] data_q;
  logic [N_DIGITS-1:0]   dp_q, blank_q;
  logic                  lz_q;
  logic [2:0]            bright_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      dp_q     <= '0;
      blank_q  <= '1;
      lz_q     <= 1'b0;
      bright_q <= 3'd0;
    end else if (frame_start) begin
      data_q   <= data;
      dp_q     <= dp;
      blank_q  <= blank;
      lz_q     <= lz_en;
      bright_q <= bright;
    end
  end

  // The boundary cycle itself must already display the values being latched,
  // so the decode sees the inputs on that cycle and the shadows otherwise.
  logic [4*N_DIGITS-1:0] data_s;
  logic [N_DIGITS-1:0]   dp_s, blank_s;
  logic                  lz_s;
  logic [2:0]            bright_s;

  assign data_s   = frame_start ? data   : data_q;
  assign dp_s     = frame_start ? dp     : dp_q;
  assign blank_s  = frame_start ? blank  : blank_q;
  assign lz_s     = frame_start ? lz_en  : lz_q;
  assign bright_s = frame_start ? bright : bright_q;

  logic [N_DIGITS-1:0] suppress;
  logic                any_nz;
  logic [3:0]          nib;
  logic                dark;
  logic [7:0]          code;
  logic                lower;
  logic [N_DIGITS-1:0] an_d;
  logic [7:0]          seg0_d, seg1_d;

  always_comb begin
    // Scan from the top digit down: digit i is a leading zero when nothing
    // at or above it is non-zero. Digit 0 is never suppressed.
    suppress = '0;
    any_nz   = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      any_nz      = any_nz | (data_s[4*i +: 4] != 4'h0);
      suppress[i] = lz_s & ~any_nz;
    end

    nib   = data_s[{dig, 2'b00} +: 4];
    dark  = blank_s[dig] | suppress[dig];
    code  = dark ? {1'b0, SEG_BLANK} : {dp_s[dig], hex_to_seg(nib)};
    lower = (dig < DigW'(Half));

    an_d   = (sub_idx <= bright_s) ? (N_DIGITS'(1) << dig) : '0;
    seg0_d = lower ? code : 8'h00;
    seg1_d = lower ? 8'h00 : code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= AnPol;
      seg0       <= SegPol;
      seg1       <= SegPol;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d ^ AnPol;
      seg0       <= seg0_d ^ SegPol;
      seg1       <= seg1_d ^ SegPol;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (N_DIGITS=8, SLOT=8, SUB=1).
// An active-high and an active-low instance share all inputs.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp, blank;
  logic        lz_en;
  logic [2:0]  bright;

  logic [7:0] an, seg0, seg1;
  logic       frame_tick;
  logic [7:0] an_al, seg0_al, seg1_al;
  logic       frame_tick_al;

  seg7_scan_ctrl #(
    .N_DIGITS   (8),
    .CLK_HZ     (8000),
    .SCAN_HZ    (1000),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .bright     (bright),
    .an         (an),
    .seg0       (seg0),
    .seg1       (seg1),
    .frame_tick (frame_tick)
  );

  seg7_scan_ctrl #(
    .N_DIGITS   (8),
    .CLK_HZ     (8000),
    .SCAN_HZ    (1000),
    .ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .bright     (bright),
    .an         (an_al),
    .seg0       (seg0_al),
    .seg1       (seg1_al),
    .frame_tick (frame_tick_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7:0] model_code(input int d, input logic [31:0] dat,
                                            input logic [7:0] dpv, input logic [7:0] blk,
                                            input logic lz);
    bit sup = 1'b0;
    if (lz && d != 0) begin
      sup = 1'b1;
      for (int j = d; j < 8; j++) if (dat[4*j +: 4] != 4'h0) sup = 1'b0;
    end
    if (blk[d] || sup) return 8'h00;
    return {dpv[d], seg_tab[dat[4*d +: 4]]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Pops one expected entry and compares both instances against it.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " an"},    an,                e.an);
    chk({tag, " seg0"},  seg0,              e.s0);
    chk({tag, " seg1"},  seg1,              e.s1);
    chk({tag, " ft"},    {7'd0, frame_tick}, {7'd0, e.ft});
    chk({tag, " an_al"}, an_al,             ~e.an);
    chk({tag, " s0_al"}, seg0_al,           ~e.s0);
    chk({tag, " s1_al"}, seg1_al,           ~e.s1);
    chk({tag, " ft_al"}, {7'd0, frame_tick_al}, {7'd0, e.ft});
  endtask

  task automatic push_reset();
    exp_t e;
    e = '{an: 8'h00, s0: 8'h00, s1: 8'h00, ft: 1'b0};
    sb.push_back(e);
  endtask

  // Drives one frame's inputs, queues 64 expected cycles, then checks them.
  // At cycle chg_at the data input is changed to chg_dat mid-frame.
  task automatic run_frame(input string name, input logic [31:0] dat, input logic [7:0] dpv,
                           input logic [7:0] blk, input logic lz, input logic [2:0] br,
                           input int chg_at, input logic [31:0] chg_dat);
    exp_t e;
    logic [7:0] code;
    data = dat; dp = dpv; blank = blk; lz_en = lz; bright = br;
    for (int k = 0; k < 64; k++) begin
      int d = k / 8;
      int s = k % 8;
      code = model_code(d, dat, dpv, blk, lz);
      e.an = (s <= int'(br)) ? (8'h01 << d) : 8'h00;
      e.s0 = (d < 4) ? code : 8'h00;
      e.s1 = (d < 4) ? 8'h00 : code;
      e.ft = (k == 0);
      sb.push_back(e);
    end
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      pop_check($sformatf("%s k=%0d", name, k));
      if (k == chg_at) data = chg_dat;
    end
  endtask

  initial begin
    rst = 1'b0;
    data = 32'h7654_3210; dp = 8'h00; blank = 8'h00; lz_en = 1'b0; bright = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    push_reset();
    pop_check("reset");

    @(negedge clk);
    rst = 1'b1;
    run_frame("base",     32'h7654_3210, 8'h00, 8'h00, 1'b0, 3'd7, -1, 32'h0);
    run_frame("lz305",    32'h0000_0305, 8'h00, 8'h00, 1'b1, 3'd7, -1, 32'h0);
    run_frame("lzzero",   32'h0000_0000, 8'h00, 8'h00, 1'b1, 3'd7, -1, 32'h0);
    run_frame("pwm2",     32'h7654_3210, 8'h00, 8'h00, 1'b0, 3'd2, -1, 32'h0);
    run_frame("pwm0",     32'h7654_3210, 8'h00, 8'h00, 1'b0, 3'd0, -1, 32'h0);
    run_frame("dpblank",  32'hFEDC_BA98, 8'hA5, 8'h24, 1'b0, 3'd7, -1, 32'h0);
    run_frame("dp0",      32'h0000_0000, 8'h01, 8'h00, 1'b1, 3'd7, -1, 32'h0);
    run_frame("ones",     32'h1111_1111, 8'h00, 8'h00, 1'b0, 3'd7, -1, 32'h0);
    run_frame("tear",     32'h1111_1111, 8'h00, 8'h00, 1'b0, 3'd7, 24, 32'h2222_2222);
    run_frame("twos",     32'h2222_2222, 8'h00, 8'h00, 1'b0, 3'd7, -1, 32'h0);

    // Reset in the middle of digit 5's slot must take effect without a clock.
    repeat (43) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    push_reset();
    pop_check("midreset");
    @(negedge clk);
    rst = 1'b1;
    run_frame("restart",  32'h2222_2222, 8'h00, 8'h00, 1'b0, 3'd7, -1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
